// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus an optional multi-cycle shift-add MUL.
// Define SEQ_ALU_MUL_EN to build the iterative multiplier; otherwise MUL returns 0 and pulses op_err.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             flags_en,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       ccr,
    output logic             op_err
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_ccr;

    assign w_accept  = in_valid && in_ready;
    // Extra top bit carries the ADD carry-out / SUB borrow.
    assign w_sum     = {1'b0, dst} + {1'b0, src};
    assign w_diff    = {1'b0, dst} - {1'b0, src};
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ccr       = r_ccr;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_PASS: w_res = dst;
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (dst[WIDTH-1] == src[WIDTH-1]) && (w_sum[WIDTH-1] != dst[WIDTH-1]);
            end
            OP_NOT:  w_res = ~src;
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (dst[WIDTH-1] != src[WIDTH-1]) && (w_diff[WIDTH-1] != dst[WIDTH-1]);
            end
            OP_AND:  w_res = dst & src;
            OP_OR:   w_res = dst | src;
            OP_XOR:  w_res = dst ^ src;
            default: w_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_mul_fe;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_acc_next;

    assign op_err     = 1'b0;
    assign w_mul_last = (r_state == ST_MUL) && (r_cnt == CW'(WIDTH - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && op == OP_MUL) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_last)               w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_IDLE);
    end

    // The accept edge already performs iteration 0, so WIDTH-1 more follow in ST_MUL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ccr       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_mul_fe    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == ST_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                if (w_mul_last) begin
                    r_result    <= w_acc_next;
                    r_out_valid <= 1'b1;
                    if (r_mul_fe) r_ccr[1:0] <= {w_acc_next[WIDTH-1], ~|w_acc_next};
                end
            end
            if (w_accept) begin
                if (op == OP_MUL) begin
                    r_acc    <= src[0] ? dst : '0;
                    r_mcand  <= dst << 1;
                    r_mplier <= src >> 1;
                    r_cnt    <= CW'(1);
                    r_mul_fe <= flags_en;
                end else begin
                    r_result    <= w_res;
                    r_out_valid <= 1'b1;
                    if (flags_en && op != OP_PASS) r_ccr <= {w_c, w_v, w_res[WIDTH-1], ~|w_res};
                end
            end
        end
    end
`else
    logic r_op_err;

    assign in_ready = 1'b1;
    assign op_err   = r_op_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_op_err    <= 1'b0;
            r_result    <= '0;
            r_ccr       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_op_err    <= 1'b0;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                if (op == OP_MUL) begin
                    r_result <= '0;
                    r_op_err <= 1'b1;
                end else begin
                    r_result <= w_res;
                    if (flags_en && op != OP_PASS) r_ccr <= {w_c, w_v, w_res[WIDTH-1], ~|w_res};
                end
            end
        end
    end
`endif

endmodule
